// File: rtl/mul_sequencer_pkg.sv
// mul_sequencer_pkg: shared FSM encoding, ALU command code and status-register bit positions
package mul_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] ADD_EXE = 4'b0010;

    localparam int SR_Z = 3;
    localparam int SR_C = 2;
    localparam int SR_N = 1;
    localparam int SR_V = 0;

endpackage

// File: rtl/mul_sequencer.sv
// mul_sequencer: MUL/MLA by shift-and-add, borrowing the shared EXE-stage ALU while running
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             accumulate,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_c,
    input  logic [3:0]       sr_in,
    input  logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_val1,
    output logic [WIDTH-1:0] alu_val2,
    output logic             alu_cin,
    output logic [3:0]       alu_exe_cmd,
    output logic             alu_grant,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       sr_out,
    output logic             sr_we
);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_acc, r_mcand, r_mplier, r_result;
    logic [CNT_W-1:0] r_cnt;
    logic             w_last;
    logic [WIDTH-1:0] w_acc_nxt, w_acc_init;

    // Stop as soon as no multiplier bits remain, bounding the run at WIDTH cycles
    assign w_last     = ((r_mplier >> 1) == '0) || (r_cnt == CNT_W'(WIDTH - 1));
    assign w_acc_nxt  = r_mplier[0] ? alu_result : r_acc;
    assign w_acc_init = accumulate ? op_c : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = start ? ((op_b != '0) ? RUN : DONE) : IDLE;
            RUN:     w_next = w_last ? DONE : RUN;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else if (r_state == IDLE && start) begin
            r_acc    <= w_acc_init;
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_cnt    <= '0;
            if (op_b == '0)
                r_result <= w_acc_init;
        end else if (r_state == RUN) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last)
                r_result <= w_acc_nxt;
        end
    end

    always_comb begin
        alu_val1    = r_acc;
        alu_val2    = r_mcand;
        alu_cin     = 1'b0;
        alu_exe_cmd = ADD_EXE;
        alu_grant   = (r_state == RUN);
        busy        = (r_state != IDLE);
        stall       = (r_state == RUN) || (r_state == IDLE && start);
        done        = (r_state == DONE);
        sr_we       = (r_state == DONE) && set_flags;
        result      = r_result;
        sr_out         = 4'b0;
        sr_out[SR_Z]   = (r_result == '0);
        sr_out[SR_C]   = sr_in[SR_C];
        sr_out[SR_N]   = r_result[WIDTH-1];
        sr_out[SR_V]   = sr_in[SR_V];
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// tb_mul_sequencer: table-driven, hand-written and random checks of mul_sequencer against a product model
module tb_mul_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        accumulate = 1'b0;
    logic        set_flags = 1'b0;
    logic [31:0] op_a = '0, op_b = '0, op_c = '0;
    logic [3:0]  sr_in = 4'b0101;
    logic [31:0] alu_result;
    logic [31:0] alu_val1, alu_val2, result;
    logic        alu_cin, alu_grant, busy, stall, done, sr_we;
    logic [3:0]  alu_exe_cmd, sr_out;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // External ALU model: plain adder
    assign alu_result = alu_val1 + alu_val2 + {31'b0, alu_cin};

    mul_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .accumulate(accumulate), .set_flags(set_flags),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .sr_in(sr_in), .alu_result(alu_result),
        .alu_val1(alu_val1), .alu_val2(alu_val2), .alu_cin(alu_cin), .alu_exe_cmd(alu_exe_cmd),
        .alu_grant(alu_grant), .busy(busy), .stall(stall), .done(done), .result(result),
        .sr_out(sr_out), .sr_we(sr_we)
    );

    typedef struct {
        logic        acc;
        logic        sf;
        logic [3:0]  sr;
        logic [31:0] a, b, c;
        logic [31:0] exp_res;
        int          exp_runs;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_sr(input logic [31:0] r, input logic [3:0] s);
        return {r == 32'd0, s[2], r[31], s[0]};
    endfunction

    function automatic int exp_runs_of(input logic [31:0] b);
        int n = 0;
        for (int i = 0; i < 32; i++)
            if (b[i]) n = i + 1;
        return n;
    endfunction

    task automatic run_op(input logic acc_i, input logic sf_i, input logic [3:0] sr_i,
                          input logic [31:0] a_i, input logic [31:0] b_i, input logic [31:0] c_i,
                          output logic [31:0] res_o, output logic [3:0] sro_o, output logic we_o,
                          output int grants, output int stalls, output int lat);
        @(negedge clk);
        accumulate = acc_i; set_flags = sf_i; sr_in = sr_i;
        op_a = a_i; op_b = b_i; op_c = c_i; start = 1'b1;
        grants = 0; lat = -1; res_o = 'x; sro_o = 'x; we_o = 1'bx;
        #1 stalls = int'(stall);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            stalls += int'(stall);
            if (done) begin
                res_o = result; sro_o = sr_out; we_o = sr_we; lat = k;
                break;
            end
            grants += int'(alu_grant);
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic count_done(input int n, output int d);
        d = 0;
        repeat (n) begin
            @(posedge clk); #1;
            d += int'(done);
        end
    endtask

    task automatic check_op(input string nm, input vec_t v);
        logic [31:0] r; logic [3:0] s; logic w; int g, st, l;
        run_op(v.acc, v.sf, v.sr, v.a, v.b, v.c, r, s, w, g, st, l);
        chk({nm, "_result"}, r, v.exp_res);
        chk({nm, "_sr_out"}, {28'b0, s}, {28'b0, exp_sr(v.exp_res, v.sr)});
        chk({nm, "_sr_we"}, {31'b0, w}, {31'b0, v.sf});
        chk({nm, "_grant_cycles"}, g, v.exp_runs);
        chk({nm, "_stall_cycles"}, st, v.exp_runs + 1);
        chk({nm, "_latency"}, l, v.exp_runs);
        chk({nm, "_idle_after"}, {31'b0, busy}, 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        int d;
        logic [31:0] r; logic [3:0] s; logic w; int g, st, l;
        vec_t v;

        vecs[0] = '{acc: 1'b0, sf: 1'b1, sr: 4'b0101, a: 32'd5, b: 32'd3, c: 32'd0, exp_res: 32'd15, exp_runs: 2};
        vecs[1] = '{acc: 1'b0, sf: 1'b1, sr: 4'b0000, a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, c: 32'd0, exp_res: 32'd1, exp_runs: 32};
        vecs[2] = '{acc: 1'b1, sf: 1'b1, sr: 4'b0000, a: 32'd7, b: 32'd6, c: 32'd100, exp_res: 32'd142, exp_runs: 3};
        vecs[3] = '{acc: 1'b1, sf: 1'b1, sr: 4'b0111, a: 32'd7, b: 32'd0, c: 32'd0, exp_res: 32'd0, exp_runs: 0};
        vecs[4] = '{acc: 1'b0, sf: 1'b0, sr: 4'b0000, a: 32'h80000000, b: 32'd1, c: 32'd0, exp_res: 32'h80000000, exp_runs: 1};
        vecs[5] = '{acc: 1'b1, sf: 1'b0, sr: 4'b1111, a: 32'd9, b: 32'd0, c: 32'h55, exp_res: 32'h55, exp_runs: 0};

        #12;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sr_we", {31'b0, sr_we}, 32'd0);
        chk("rst_grant", {31'b0, alu_grant}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_sr_out", {28'b0, sr_out}, 32'b1101);
        chk("rst_val1", alu_val1, 32'd0);
        chk("alu_cin", {31'b0, alu_cin}, 32'd0);
        chk("alu_cmd", {28'b0, alu_exe_cmd}, 32'b0010);
        @(negedge clk); rst = 1'b1;

        foreach (vecs[i]) check_op($sformatf("vec%0d", i), vecs[i]);

        // start re-asserted during RUN and DONE must be ignored
        @(negedge clk);
        accumulate = 1'b0; set_flags = 1'b1; op_a = 32'd9; op_b = 32'h0F; op_c = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        op_a = 32'd1; op_b = 32'd1; op_c = 32'd77; accumulate = 1'b1;
        d = 0; l = -1;
        for (int k = 0; k < 40; k++) begin
            if (done) begin l = k; break; end
            @(posedge clk); #1;
        end
        chk("ign_latency", l, 4);
        chk("ign_result", result, 32'd135);
        @(posedge clk); #1;
        start = 1'b0;
        count_done(10, d);
        chk("ign_extra_done", d, 0);
        chk("ign_result_held", result, 32'd135);

        // asynchronous reset in the 10th RUN cycle
        @(negedge clk);
        accumulate = 1'b0; sr_in = 4'b0101; op_a = 32'h1234; op_b = 32'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 chk("mid_grant", {31'b0, alu_grant}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_grant", {31'b0, alu_grant}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_sr_out", {28'b0, sr_out}, 32'b1101);
        count_done(2, d);
        @(negedge clk); rst = 1'b1;
        count_done(20, g);
        chk("mid_rst_no_done", d + g, 0);
        v = '{acc: 1'b0, sf: 1'b1, sr: 4'b0000, a: 32'd2, b: 32'd2, c: 32'd0, exp_res: 32'd4, exp_runs: 2};
        check_op("after_rst", v);

        for (int i = 0; i < 40; i++) begin
            v.acc = 1'($urandom);
            v.sf  = 1'($urandom);
            v.sr  = 4'($urandom);
            v.a   = $urandom;
            v.b   = (i % 8 == 7) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            v.c   = $urandom;
            v.exp_res  = v.a * v.b + (v.acc ? v.c : 32'd0);
            v.exp_runs = exp_runs_of(v.b);
            check_op($sformatf("rnd%0d", i), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
